io_uart_transmitter: RTL and testbench
======================================

IO_UART_TRANSMITTER -- requirements
Module: io_uart_transmitter

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (115200 baud at 50 MHz); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, byte FIFO entries; power of two, 2..16.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 io_value  input  8  memory-mapped output byte from the processor core (its output_io).
REQ-006 uart_tx  output  1  serial line, 8N1, idle high, registered.
REQ-007 busy  output  1  high while FIFO non-empty or a frame is in progress.
REQ-008 overflow  output  1  sticky flag, set when a byte is dropped on a full FIFO.
REQ-009 fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-010 Change detect: a register last_value SHALL hold the most recently captured io_value; on each edge where io_value != last_value, last_value <= io_value and a push of io_value is requested.
REQ-011 Push latency: a value stable at io_value before edge N is enqueued at edge N; fifo_count reflects it after edge N.
REQ-012 Push on full FIFO with no same-edge pop: byte dropped, overflow <= 1, last_value still updated.
REQ-013 Push and pop on the same edge SHALL both take effect, including when full; fifo_count unchanged.
REQ-014 Pop on empty FIFO SHALL never occur; the FSM only pops when fifo_count != 0.
REQ-015 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; ordering strictly FIFO.
REQ-016 TX FSM states: IDLE, START, DATA, STOP.
REQ-017 IDLE: uart_tx = 1; if fifo_count != 0, pop head into shift register, load bit counter 0, clear baud counter, go START.
REQ-018 START: uart_tx = 0 for exactly CLKS_PER_BIT cycles, then DATA.
REQ-019 DATA: 8 bits LSB first, each held exactly CLKS_PER_BIT cycles; after bit 7, go STOP.
REQ-020 STOP: uart_tx = 1 for exactly CLKS_PER_BIT cycles, then IDLE.
REQ-021 Frame length is exactly 10*CLKS_PER_BIT cycles; exactly one IDLE cycle separates back-to-back frames.
REQ-022 uart_tx transitions SHALL be glitch-free (driven from a flop, not decoded state).
REQ-023 busy = (state != IDLE) || (fifo_count != 0), combinational from registered state.
REQ-024 overflow clears only on reset.

Reset
REQ-025 Asserting reset at any time, including mid-frame, SHALL immediately force: state IDLE, uart_tx 1, FIFO empty (fifo_count 0), pointers 0, baud and bit counters 0, overflow 0, last_value 8'h00.
REQ-026 A partially sent frame is abandoned on reset; no resumption after release.
REQ-027 First edge after reset release with io_value != 8'h00 SHALL enqueue io_value.

Structure
REQ-028 Shared package io_pkg SHALL hold the TX state enumeration and the default CLKS_PER_BIT constant.
REQ-029 FIFO SHALL be a sub-module byte_fifo (parameter DEPTH; push, pop, data in/out, count, full, empty); the FSM, change detector, and baud counter stay in io_uart_transmitter.

Verification (CLKS_PER_BIT = 4, FIFO_DEPTH = 4)
REQ-030 io_value 00->A5 -> fifo_count 1 after one edge; uart_tx low 4 cycles, then bits 1,0,1,0,0,1,0,1 of 4 cycles each, then high 4 cycles; 40 cycles total; busy falls after STOP.
REQ-031 io_value 01,02,03 on consecutive cycles -> three frames 01,02,03 in order, each 40 cycles, 1 idle cycle between; overflow stays 0.
REQ-032 Six distinct values on consecutive cycles while the first frame is active -> the first is popped, four are queued, the sixth is dropped; overflow = 1; transmitted 1st through 5th.
REQ-033 io_value held at 5A for 200 cycles -> exactly one frame; a repeated identical value is never re-sent.
REQ-034 Reset asserted asynchronously at cycle 17 of a frame -> uart_tx = 1, fifo_count = 0, busy = 0 before the next edge; no further frames until io_value changes.
REQ-035 FIFO full with pop and push on the same edge -> fifo_count stays 4; new byte sent last; overflow stays 0.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: TX state encoding and baud default.
package io_pkg;

   localparam int unsigned DefaultClksPerBit = 434;

   typedef logic [1:0] tx_state_t;

   localparam tx_state_t StIdle  = 2'd0;
   localparam tx_state_t StStart = 2'd1;
   localparam tx_state_t StData  = 2'd2;
   localparam tx_state_t StStop  = 2'd3;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with power-of-two depth; simultaneous push and pop both succeed even when full.
module byte_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [7:0]               wdata_i,
   output logic [7:0]               rdata_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] DepthC = (AW + 1)'(DEPTH);
   localparam logic [AW:0] OneC   = (AW + 1)'(1);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          push_ok, pop_ok;

   assign full_o  = (count_q == DepthC);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign push_ok = push_i && (!full_o || pop_i);
   assign pop_ok  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + OneC;
         2'b01:   count_d = count_q - OneC;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/io_uart_transmitter.sv
// Sends each new value written to the processor output port as an 8N1 UART frame,
// buffering bursts in a small byte FIFO.
module io_uart_transmitter
   import io_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [7:0]                    io_value,
   output logic                          uart_tx,
   output logic                          busy,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam logic [15:0] BaudLast = 16'(CLKS_PER_BIT - 1);

   tx_state_t   state_q, state_d;
   logic [7:0]  last_value_q, last_value_d;
   logic [7:0]  shift_q, shift_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [15:0] baud_cnt_q, baud_cnt_d;
   logic        tx_q, tx_d;
   logic        overflow_q, overflow_d;

   logic        push, pop, baud_done;
   logic [7:0]  fifo_rdata;
   logic        fifo_full, fifo_empty;

   byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (reset),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (io_value),
      .rdata_o (fifo_rdata),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign push      = (io_value != last_value_q);
   assign baud_done = (baud_cnt_q == BaudLast);

   always_comb begin
      state_d      = state_q;
      last_value_d = push ? io_value : last_value_q;
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      baud_cnt_d   = baud_cnt_q;
      tx_d         = tx_q;
      pop          = 1'b0;

      // tx_d is the line level for the coming cycle, so uart_tx comes straight from a flop.
      case (state_q)
         StIdle: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               pop        = 1'b1;
               shift_d    = fifo_rdata;
               bit_cnt_d  = '0;
               baud_cnt_d = '0;
               state_d    = StStart;
               tx_d       = 1'b0;
            end
         end
         StStart: begin
            if (baud_done) begin
               baud_cnt_d = '0;
               state_d    = StData;
               tx_d       = shift_q[0];
            end else begin
               baud_cnt_d = baud_cnt_q + 16'd1;
            end
         end
         StData: begin
            if (baud_done) begin
               baud_cnt_d = '0;
               if (bit_cnt_q == 3'd7) begin
                  state_d = StStop;
                  tx_d    = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  shift_d   = {1'b0, shift_q[7:1]};
                  tx_d      = shift_q[1];
               end
            end else begin
               baud_cnt_d = baud_cnt_q + 16'd1;
            end
         end
         StStop: begin
            tx_d = 1'b1;
            if (baud_done) begin
               baud_cnt_d = '0;
               state_d    = StIdle;
            end else begin
               baud_cnt_d = baud_cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = StIdle;
            tx_d    = 1'b1;
         end
      endcase

      overflow_d = overflow_q | (push && fifo_full && !pop);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         last_value_q <= 8'h00;
         shift_q      <= 8'h00;
         bit_cnt_q    <= '0;
         baud_cnt_q   <= '0;
         tx_q         <= 1'b1;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_value_q <= last_value_d;
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         baud_cnt_q   <= baud_cnt_d;
         tx_q         <= tx_d;
         overflow_q   <= overflow_d;
      end
   end

   assign uart_tx  = tx_q;
   assign overflow = overflow_q;
   assign busy     = (state_q != StIdle) || (fifo_count != '0);

endmodule

// File: tb/tb_io_uart_transmitter.sv
// Scoreboard bench: a line monitor decodes every frame and compares it against the queued bytes.
module tb_io_uart_transmitter;

   localparam int CPB   = 4;
   localparam int FLEN  = 10 * CPB;

   logic       clk;
   logic       reset;
   logic [7:0] io_value;
   logic       uart_tx;
   logic       busy;
   logic       overflow;
   logic [2:0] fifo_count;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int frames   = 0;
   logic [7:0] exp_q[$];
   int         starts[$];

   io_uart_transmitter #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .io_value   (io_value),
      .uart_tx    (uart_tx),
      .busy       (busy),
      .overflow   (overflow),
      .fifo_count (fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic put(input logic [7:0] v, input bit sent);
      io_value = v;
      if (sent) exp_q.push_back(v);
   endtask

   task automatic wait_idle(input int budget, output int n);
      n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (busy) check_eq("idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic do_reset(input logic [7:0] v_after);
      @(negedge clk);
      io_value = 8'h00;
      reset    = 1'b1;
      exp_q.delete();
      repeat (2) @(negedge clk);
      check_eq("rst_tx", 32'(uart_tx), 32'd1);
      check_eq("rst_count", 32'(fifo_count), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_overflow", 32'(overflow), 32'd0);
      io_value = v_after;
      reset    = 1'b0;
      starts.delete();
   endtask

   // Line monitor: captures FLEN samples from the first low level, abandons on reset.
   initial begin : monitor
      logic [FLEN-1:0] s;
      logic [7:0]      b;
      bit              abort;
      int              bad;
      int              st;
      forever begin
         @(negedge clk);
         if (!reset && uart_tx === 1'b0) begin
            st    = cyc;
            s     = '1;
            s[0]  = uart_tx;
            abort = 1'b0;
            for (int k = 1; k < FLEN; k++) begin
               @(negedge clk);
               if (reset) begin
                  abort = 1'b1;
                  break;
               end
               s[k] = uart_tx;
            end
            if (!abort) begin
               bad = 0;
               for (int i = 0; i < 10; i++)
                  for (int j = 1; j < CPB; j++)
                     if (s[i*CPB+j] !== s[i*CPB]) bad++;
               check_eq("bit_hold", 32'(bad), 32'd0);
               check_eq("stop_bit", 32'(s[9*CPB]), 32'd1);
               for (int i = 0; i < 8; i++) b[i] = s[(i+1)*CPB];
               if (exp_q.size() == 0) check_eq("frame_unexpected", {24'h0, b}, 32'h100);
               else check_eq("frame_data", {24'h0, b}, {24'h0, exp_q.pop_front()});
               frames++;
               starts.push_back(st);
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n;
      int f0;
      reset    = 1'b1;
      io_value = 8'h00;
      do_reset(8'h00);

      // Single frame of A5.
      @(negedge clk);
      put(8'hA5, 1'b1);
      @(negedge clk);
      check_eq("a5_count", 32'(fifo_count), 32'd1);
      check_eq("a5_busy", 32'(busy), 32'd1);
      wait_idle(200, n);
      check_eq("a5_busy_len", 32'(n), 32'(FLEN + 1));
      check_eq("a5_sb_empty", 32'(exp_q.size()), 32'd0);

      // Three back-to-back frames.
      starts.delete();
      put(8'h01, 1'b1);
      @(negedge clk);
      put(8'h02, 1'b1);
      @(negedge clk);
      put(8'h03, 1'b1);
      @(negedge clk);
      wait_idle(500, n);
      check_eq("b2b_frames", 32'(starts.size()), 32'd3);
      if (starts.size() == 3) begin
         check_eq("b2b_gap1", 32'(starts[1] - starts[0]), 32'(FLEN + 1));
         check_eq("b2b_gap2", 32'(starts[2] - starts[1]), 32'(FLEN + 1));
      end
      check_eq("b2b_overflow", 32'(overflow), 32'd0);
      check_eq("b2b_sb_empty", 32'(exp_q.size()), 32'd0);

      // Six values in a burst: sixth dropped, overflow sticky until reset.
      put(8'h11, 1'b1);
      @(negedge clk);
      put(8'h22, 1'b1);
      @(negedge clk);
      put(8'h33, 1'b1);
      @(negedge clk);
      put(8'h44, 1'b1);
      @(negedge clk);
      put(8'h55, 1'b1);
      @(negedge clk);
      put(8'h66, 1'b0);
      @(negedge clk);
      check_eq("ovf_count", 32'(fifo_count), 32'd4);
      check_eq("ovf_flag", 32'(overflow), 32'd1);
      wait_idle(1000, n);
      check_eq("ovf_sticky", 32'(overflow), 32'd1);
      check_eq("ovf_sb_empty", 32'(exp_q.size()), 32'd0);

      // Value already present at reset release is sent once, then never repeated.
      do_reset(8'h5A);
      exp_q.push_back(8'h5A);
      f0 = frames;
      @(negedge clk);
      check_eq("hold_first_push", 32'(fifo_count), 32'd1);
      repeat (200) @(negedge clk);
      check_eq("hold_one_frame", 32'(frames - f0), 32'd1);
      check_eq("hold_sb_empty", 32'(exp_q.size()), 32'd0);

      // Asynchronous reset in cycle 17 of a frame.
      do_reset(8'h00);
      @(negedge clk);
      io_value = 8'hC3;
      @(negedge clk);
      io_value = 8'h3C;
      repeat (16) @(negedge clk);
      check_eq("mid_tx_low", 32'(uart_tx), 32'd0);
      check_eq("mid_count", 32'(fifo_count), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check_eq("async_tx", 32'(uart_tx), 32'd1);
      check_eq("async_count", 32'(fifo_count), 32'd0);
      check_eq("async_busy", 32'(busy), 32'd0);
      @(negedge clk);
      io_value = 8'h00;
      @(negedge clk);
      reset = 1'b0;
      f0    = frames;
      repeat (100) @(negedge clk);
      check_eq("post_rst_frames", 32'(frames - f0), 32'd0);
      check_eq("post_rst_busy", 32'(busy), 32'd0);

      // Full FIFO with push on the exact pop edge.
      do_reset(8'h00);
      @(negedge clk);
      put(8'h71, 1'b1);
      @(negedge clk);
      put(8'h72, 1'b1);
      @(negedge clk);
      put(8'h73, 1'b1);
      @(negedge clk);
      put(8'h74, 1'b1);
      @(negedge clk);
      put(8'h75, 1'b1);
      @(negedge clk);
      check_eq("full_count", 32'(fifo_count), 32'd4);
      repeat (FLEN - 3) @(negedge clk);
      check_eq("full_before_pop", 32'(fifo_count), 32'd4);
      put(8'h76, 1'b1);
      @(negedge clk);
      check_eq("pushpop_count", 32'(fifo_count), 32'd4);
      check_eq("pushpop_overflow", 32'(overflow), 32'd0);
      wait_idle(1000, n);
      check_eq("pushpop_sb_empty", 32'(exp_q.size()), 32'd0);
      check_eq("pushpop_ovf_final", 32'(overflow), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
